ram_port_arbiter: RTL

//  Shares the single-port, 1-cycle-read-latency word RAM between the CPU instruction-fetch

---
 rtl/ram_port_arbiter_if.sv | 37 +++
 rtl/ram_port_arbiter.sv | 64 ++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the fetch, load/store and RAM-side signals around the RAM port arbiter.
// The slave modport is the arbiter's view; master is the core/RAM side.
interface ram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 32
) ();
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              ram_wren;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_q,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output ram_wren, ram_address, ram_data
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_q,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  ram_wren, ram_address, ram_data
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares a single-port, 1-cycle-latency RAM between instruction fetch (I) and load/store (D).
// D has priority unless I has been denied MAX_WAIT consecutive cycles.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W   = 30,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_port_arbiter_if.slave   bus
);
    localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

    typedef enum logic [1:0] {OwnNone, OwnI, OwnD} owner_e;

    owner_e     owner_q, owner_d;
    logic [3:0] wait_q, wait_d;
    logic       force_i;
    logic       i_gnt, d_gnt;

    assign force_i = (wait_q == MaxWaitC);
    assign d_gnt   = bus.d_req & ~(bus.i_req & force_i);
    assign i_gnt   = bus.i_req & ~d_gnt;

    assign bus.i_gnt       = i_gnt;
    assign bus.d_gnt       = d_gnt;
    assign bus.ram_address = d_gnt ? bus.d_addr : bus.i_addr;
    assign bus.ram_data    = bus.d_wdata;
    // Gated by rst_n so no write can reach the RAM while reset is held.
    assign bus.ram_wren    = d_gnt & bus.d_we & rst_n;

    assign bus.i_rvalid = (owner_q == OwnI);
    assign bus.d_rvalid = (owner_q == OwnD);
    assign bus.i_rdata  = bus.ram_q;
    assign bus.d_rdata  = bus.ram_q;

    always_comb begin
        owner_d = OwnNone;
        if (i_gnt) begin
            owner_d = OwnI;
        end else if (d_gnt && !bus.d_we) begin
            owner_d = OwnD;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (!bus.i_req || i_gnt) begin
            wait_d = 4'd0;
        end else if (wait_q != MaxWaitC) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OwnNone;
            wait_q  <= 4'd0;
        end else begin
            owner_q <= owner_d;
            wait_q  <= wait_d;
        end
    end
endmodule
